// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N one-hot decoder with a timed scan mode.
// Direct mode decodes x one cycle after a load. Scan mode walks the one-hot
// code through all 2^N positions starting at x, holding each code HOLD cycles,
// then pulses done.
// Optional feature: define DEC_SCAN_ACTIVE_LOW_EN to drive d active-low.
module dec_scan_n #(
    parameter int unsigned N    = 2,
    parameter int unsigned HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            mode_i,
    input  logic            load_i,
    input  logic [N-1:0]    x_i,
    output logic [2**N-1:0] d_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CntLast = CW'(HOLD - 1);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e         state_q;
    logic [N-1:0]   idx_q;
    logic [N-1:0]   start_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   d_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;

    logic [N-1:0]   idx_nxt;

    // Next scan position, wrapping naturally at 2^N.
    always_comb begin
        idx_nxt = idx_q + N'(1);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDirect: begin
                    if (en_i && load_i) begin
                        d_q     <= W'(1) << x_i;
                        valid_q <= 1'b1;
                        if (mode_i) begin
                            state_q <= StScan;
                            idx_q   <= x_i;
                            start_q <= x_i;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StDirect;
                        end
                    end else if (!en_i && (state_q == StDirect)) begin
                        d_q     <= '0;
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StScan: begin
                    // en low freezes everything; loads are ignored while scanning.
                    if (en_i) begin
                        if (cnt_q == CntLast) begin
                            cnt_q <= '0;
                            // Returning to the start code means all 2^N codes were shown.
                            if (idx_nxt == start_q) begin
                                d_q     <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                idx_q <= idx_nxt;
                                d_q   <= W'(1) << idx_nxt;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DEC_SCAN_ACTIVE_LOW_EN
    assign d_o = ~d_q;
`else
    assign d_o = d_q;
`endif
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: doc/dec_scan_n.md
Name: dec_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor of the fixed 2-to-4 combinational decoder.
- Adds two modes: direct decode (1-cycle latency), and a timed scan that walks the one-hot output through every code starting from a loaded index.
- Drives strobe/select lines (LED digit select, bank select) in the lab designs.

Parameters:
- N, 2, select input width; output width is 2^N; legal range 1..6.
- HOLD, 4, cycles each one-hot code is held during scan; legal range >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; one clock domain only.
- en  input  1  global enable; pauses operation when low.
- mode  input  1  0 = direct decode, 1 = scan.
- load  input  1  command strobe; sampled on a rising clk edge.
- x  input  N  select code or scan start index.
- d  output  2^N  registered one-hot decode (bit x high).
- valid  output  1  d holds a decoded code.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (async assert, sync release):
  - d = 0, valid = 0, busy = 0, done = 0.
  - State IDLE; internal index = 0; hold counter = 0.
- States: IDLE, DIRECT, SCAN.
- IDLE:
  - en & load & !mode -> DIRECT; next edge d = 1 << x, valid = 1.
  - en & load & mode -> SCAN; next edge index = x, d = 1 << x, valid = 1, busy = 1, hold counter = 0.
  - Otherwise d, valid hold their values (both 0 after reset).
- DIRECT:
  - en & load & !mode -> d = 1 << x next edge; latency exactly 1 cycle.
  - en & load & mode -> enter SCAN exactly as from IDLE.
  - en low -> next edge d = 0, valid = 0, state IDLE.
  - No load -> d holds.
- SCAN:
  - Hold counter increments each en-high cycle.
  - When counter reaches HOLD-1: counter = 0; index = (index + 1) mod 2^N, wrapping from 2^N-1 to 0; d = 1 << new index.
  - Each code is therefore held HOLD cycles.
  - After 2^N codes have each been held HOLD cycles (2^N * HOLD en-high cycles total), the next edge sets d = 0, valid = 0, busy = 0, done = 1 for one cycle, state IDLE.
  - The start code is not re-asserted at the end.
- en low in SCAN: counter, index and d all frozen; busy stays 1; resumes on en high with no lost cycle.
- load during SCAN: ignored, including mode or x changes.
- load while en low: ignored in every state.
- done:
  - High only for the single cycle after the final scan step.
  - A load in that same cycle (state IDLE) is accepted normally.
- Width rules:
  - Index and x are N bits; counter is clog2(HOLD) bits, minimum 1.
  - HOLD = 1 advances the code every en-high cycle.
- Reset mid-scan: immediately returns all outputs to reset values; no done pulse.
- d is always one-hot or all-zero; valid = 1 iff d is nonzero.

Optional Feature:
- Macro: DEC_SCAN_ACTIVE_LOW_EN.
- Defined:
  - d output is bitwise inverted (active-low one-hot, 74x139 style).
  - Reset and idle value of d is all ones.
  - valid, busy, done unaffected.
  - Internal state and timing identical.
- Undefined: active-high d as described above.

Test Plan:
- Reset, N=2: assert rst mid-cycle -> d=4'b0000, valid=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Direct decode, N=2: en=1, mode=0, load x=0,1,2,3 on consecutive cycles -> d=0001, 0010, 0100, 1000, each one cycle after its load; valid=1 throughout. Then drop en -> next cycle d=0000, valid=0.
- Scan with wrap, N=2, HOLD=2: load mode=1, x=2 -> d sequence 0100 x2, 1000 x2, 0001 x2, 0010 x2; then d=0000 with done=1 for exactly one cycle; busy=1 for exactly 8 cycles.
- Pause and ignore, HOLD=2: during scan drop en for 3 cycles -> d and busy frozen, total scan length extends by 3. A load with x=0 mid-scan -> no effect on the sequence.
- Reset mid-scan, N=3, HOLD=4: assert rst at code index 5 -> d=0, busy=0, no done pulse. A fresh direct load x=6 afterwards -> d=8'b01000000.
- With DEC_SCAN_ACTIVE_LOW_EN, N=2: after reset d=1111. Direct load x=1 -> d=1101, valid=1.
